// File: rtl/pixel_replicator.sv
// Nearest-neighbour line replicator: buffers one native row, then replays it SCALE times
// with each pixel repeated SCALE times and one idle cycle after every replayed row.
module pixel_replicator #(
  parameter int IMG_W = 384,
  parameter int IMG_H = 216,
  parameter int SCALE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixel_in,
  input  logic        input_valid,
  output logic        input_ready,
  output logic [23:0] pixel_out,
  output logic        output_valid,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int HW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [SW-1:0] LAST_REP = SW'(SCALE - 1);
  localparam logic [HW-1:0] LAST_ROW = HW'(IMG_H - 1);

  typedef enum logic [1:0] {FILL, EMIT, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic [SW-1:0] rep_px_q, rep_px_d;
  logic [SW-1:0] rep_row_q, rep_row_d;
  logic [HW-1:0] row_cnt_q, row_cnt_d;
  logic [23:0]   pix_q, pix_d;
  logic          vld_q, vld_d;
  logic          done_q, done_d;
  logic          wr_en;
  logic [23:0]   line_buf [IMG_W];

  assign input_ready  = (state_q == FILL);
  assign pixel_out    = pix_q;
  assign output_valid = vld_q;
  assign frame_done   = done_q;

  always_comb begin
    state_d   = state_q;
    wr_col_d  = wr_col_q;
    rd_col_d  = rd_col_q;
    rep_px_d  = rep_px_q;
    rep_row_d = rep_row_q;
    row_cnt_d = row_cnt_q;
    pix_d     = '0;
    vld_d     = 1'b0;
    done_d    = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      FILL: begin
        if (input_valid) begin
          wr_en = 1'b1;
          if (wr_col_q == LAST_COL) begin
            wr_col_d  = '0;
            rd_col_d  = '0;
            rep_px_d  = '0;
            rep_row_d = '0;
            state_d   = EMIT;
          end else begin
            wr_col_d = wr_col_q + 1'b1;
          end
        end
      end
      EMIT: begin
        // Read result is registered, so the output stream trails the read by one cycle.
        vld_d = 1'b1;
        pix_d = line_buf[rd_col_q];
        if (rep_px_q == LAST_REP) begin
          rep_px_d = '0;
          if (rd_col_q == LAST_COL) begin
            state_d = GAP;
          end else begin
            rd_col_d = rd_col_q + 1'b1;
          end
        end else begin
          rep_px_d = rep_px_q + 1'b1;
        end
      end
      GAP: begin
        if (rep_row_q != LAST_REP) begin
          rep_row_d = rep_row_q + 1'b1;
          rd_col_d  = '0;
          rep_px_d  = '0;
          state_d   = EMIT;
        end else if (row_cnt_q == LAST_ROW) begin
          row_cnt_d = '0;
          done_d    = 1'b1;
          state_d   = FILL;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wr_col_q  <= '0;
      rd_col_q  <= '0;
      rep_px_q  <= '0;
      rep_row_q <= '0;
      row_cnt_q <= '0;
      pix_q     <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_col_q  <= wr_col_d;
      rd_col_q  <= rd_col_d;
      rep_px_q  <= rep_px_d;
      rep_row_q <= rep_row_d;
      row_cnt_q <= row_cnt_d;
      pix_q     <= pix_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
    end
  end

  // Buffer storage carries no reset; contents are always rewritten before replay.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      line_buf[wr_col_q] <= pixel_in;
    end
  end

endmodule
